// File: rtl/world_pkg.sv
// ============================================================================
// Module  : world_pkg
// Brief   : Shared geometry, row type, dumper state encoding and popcount helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package world_pkg;

    localparam int ROWS  = 64;
    localparam int COLS  = 64;
    localparam int ROW_W = 6;
    localparam int COL_W = 6;
    localparam int POP_W = 13;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [0:0] {
        DUMP_IDLE   = 1'b0,
        DUMP_STREAM = 1'b1
    } dump_state_t;

    function automatic logic [COL_W:0] row_popcount(input row_t r);
        logic [COL_W:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + {{COL_W{1'b0}}, r[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/world_dumper.sv
// ============================================================================
// Module  : world_dumper
// Brief   : Snapshot shadow array streamed out one row per valid/ready beat.
//           STORE_POPCOUNT_EN adds dump_pop, the live-cell total on the last beat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module world_dumper
    import world_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int GEN_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       snap_req,
    input  logic [ROWS-1:0][COLS-1:0]  snap_world,
    input  logic [GEN_W-1:0]           snap_gen,
    input  logic                       dump_ready,
    output logic                       dump_valid,
    output logic [COLS-1:0]            dump_data,
    output logic [ROW_W-1:0]           dump_row,
    output logic                       dump_last,
    output logic [GEN_W-1:0]           dump_gen,
    output logic                       dump_overrun
`ifdef STORE_POPCOUNT_EN
    ,
    output logic [POP_W-1:0]           dump_pop
`endif
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    dump_state_t               state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] shadow_q, shadow_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [GEN_W-1:0]          gen_q, gen_d;
    logic                      overrun_q, overrun_d;
    logic                      beat;

    assign dump_valid   = (state_q == DUMP_STREAM);
    assign dump_data    = shadow_q[row_q];
    assign dump_row     = row_q;
    assign dump_last    = dump_valid && (row_q == LAST_ROW);
    assign dump_gen     = gen_q;
    assign dump_overrun = overrun_q;
    assign beat         = dump_valid && dump_ready;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        row_d     = row_q;
        gen_d     = gen_q;
        overrun_d = overrun_q;
        case (state_q)
            DUMP_IDLE: begin
                if (snap_req) begin
                    shadow_d = snap_world;
                    gen_d    = snap_gen;
                    row_d    = '0;
                    state_d  = DUMP_STREAM;
                end
            end
            DUMP_STREAM: begin
                // A boundary while streaming loses that snapshot for good.
                if (snap_req) begin
                    overrun_d = 1'b1;
                end
                if (beat) begin
                    row_d = row_q + ROW_W'(1);
                    if (row_q == LAST_ROW) begin
                        state_d = DUMP_IDLE;
                    end
                end
            end
            default: state_d = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DUMP_IDLE;
            shadow_q  <= '0;
            row_q     <= '0;
            gen_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            row_q     <= row_d;
            gen_q     <= gen_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef STORE_POPCOUNT_EN
    logic [POP_W-1:0] pop_q, pop_d;
    logic [POP_W-1:0] row_pop;

    assign row_pop  = POP_W'(row_popcount(dump_data));
    assign dump_pop = dump_last ? (pop_q + row_pop) : '0;

    always_comb begin
        pop_d = pop_q;
        if (state_q == DUMP_IDLE && snap_req) begin
            pop_d = '0;
        end else if (beat) begin
            pop_d = pop_q + row_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/world_store.sv
// ============================================================================
// Module  : world_store
// Brief   : 64x64 world array with automaton cell port, staged host load with
//           atomic commit, and per-generation snapshot dump (STORE_POPCOUNT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module world_store
    import world_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int GEN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROW_W-1:0]    row,
    input  logic [COL_W-1:0]    col,
    input  logic                world_we,
    input  logic                world_out,
    output logic                world_in,
    input  logic                update_done,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [COLS-1:0]     ld_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [COLS-1:0]     dump_data,
    output logic [ROW_W-1:0]    dump_row,
    output logic                dump_last,
    output logic [GEN_W-1:0]    dump_gen,
    output logic                dump_overrun
`ifdef STORE_POPCOUNT_EN
    ,
    output logic [POP_W-1:0]    dump_pop
`endif
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROWS-1:0][COLS-1:0] world_q, world_d;
    logic [ROWS-1:0][COLS-1:0] staging_q, staging_d;
    logic [ROW_W-1:0]          ld_cnt_q, ld_cnt_d;
    logic [GEN_W-1:0]          gen_cnt_q, gen_cnt_d;
    logic                      pending_q, pending_d;
    logic                      ld_fire;
    logic                      commit;

    assign world_in = world_q[row][col];
    assign ld_ready = !pending_q;
    assign ld_fire  = ld_valid && ld_ready;
    assign commit   = update_done && pending_q;

    always_comb begin
        world_d   = world_q;
        staging_d = staging_q;
        ld_cnt_d  = ld_cnt_q;
        pending_d = pending_q;
        gen_cnt_d = gen_cnt_q;

        if (world_we) begin
            world_d[row][col] = world_out;
        end

        if (ld_fire) begin
            staging_d[ld_cnt_q] = ld_data;
            ld_cnt_d            = ld_cnt_q + ROW_W'(1);
            if (ld_cnt_q == LAST_ROW) begin
                pending_d = 1'b1;
            end
        end

        if (update_done) begin
            gen_cnt_d = gen_cnt_q + GEN_W'(1);
        end

        // Commit replaces the whole world, so it wins over a same-edge cell write.
        if (commit) begin
            world_d   = staging_q;
            pending_d = 1'b0;
            gen_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            world_q   <= '0;
            staging_q <= '0;
            ld_cnt_q  <= '0;
            pending_q <= 1'b0;
            gen_cnt_q <= '0;
        end else begin
            world_q   <= world_d;
            staging_q <= staging_d;
            ld_cnt_q  <= ld_cnt_d;
            pending_q <= pending_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    world_dumper #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .GEN_W (GEN_W)
    ) u_dumper (
        .clk          (clk),
        .rst_n        (rst_n),
        .snap_req     (update_done),
        .snap_world   (world_q),
        .snap_gen     (gen_cnt_q + GEN_W'(1)),
        .dump_ready   (dump_ready),
        .dump_valid   (dump_valid),
        .dump_data    (dump_data),
        .dump_row     (dump_row),
        .dump_last    (dump_last),
        .dump_gen     (dump_gen),
        .dump_overrun (dump_overrun)
`ifdef STORE_POPCOUNT_EN
        ,
        .dump_pop     (dump_pop)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_world_store.sv
// ============================================================================
// Module  : tb_world_store
// Brief   : Scoreboard bench for world_store; dump beats checked by a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_world_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  row, col;
    logic        world_we, world_out, world_in;
    logic        update_done;
    logic        ld_valid, ld_ready;
    logic [63:0] ld_data;
    logic        dump_valid, dump_ready;
    logic [63:0] dump_data;
    logic [5:0]  dump_row;
    logic        dump_last;
    logic [15:0] dump_gen;
    logic        dump_overrun;
`ifdef STORE_POPCOUNT_EN
    logic [12:0] dump_pop;
`endif

    always #5 clk = ~clk;

    world_store dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .world_we     (world_we),
        .world_out    (world_out),
        .world_in     (world_in),
        .update_done  (update_done),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_row     (dump_row),
        .dump_last    (dump_last),
        .dump_gen     (dump_gen),
        .dump_overrun (dump_overrun)
`ifdef STORE_POPCOUNT_EN
        ,
        .dump_pop     (dump_pop)
`endif
    );

    typedef struct {
        logic [5:0]  row;
        logic [63:0] data;
        logic        last;
        logic [15:0] gen;
        logic [12:0] pop;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [63:0] mdl_world[64];
    logic [63:0] mdl_staging[64];
    bit          mdl_pending;
    logic [15:0] mdl_gen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_dump(input logic [15:0] gen);
        exp_t e;
        int   total;
        total = 0;
        for (int r = 0; r < 64; r++) begin
            total  += $countones(mdl_world[r]);
            e.row  = 6'(r);
            e.data = mdl_world[r];
            e.last = (r == 63);
            e.gen  = gen;
            e.pop  = (r == 63) ? 13'(total) : 13'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic write_cell(input int r, input int c, input logic v);
        @(posedge clk); #1;
        row = 6'(r); col = 6'(c); world_we = 1'b1; world_out = v;
        mdl_world[r][c] = v;
        @(posedge clk); #1;
        world_we = 1'b0;
    endtask

    task automatic pulse_update(input bit expect_dump);
        @(posedge clk); #1;
        update_done = 1'b1;
        if (expect_dump) push_dump(mdl_gen + 16'd1);
        mdl_gen = mdl_gen + 16'd1;
        if (mdl_pending) begin
            for (int r = 0; r < 64; r++) mdl_world[r] = mdl_staging[r];
            mdl_pending = 1'b0;
            mdl_gen     = 16'd0;
        end
        @(posedge clk); #1;
        update_done = 1'b0;
        ld_valid    = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int cycles);
        cycles = 0;
        while (dump_valid && cycles < max) begin
            cycles++;
            @(posedge clk); #1;
        end
        if (dump_valid) begin
            checks++;
            failures++;
            $display("FAIL dump_timeout: dump_valid still 1 after %0d cycles", max);
        end
    endtask

    task automatic load_world(input bit diag);
        logic [63:0] d;
        for (int r = 0; r < 64; r++) begin
            @(posedge clk); #1;
            if (diag) d = 64'h1 << r;
            else      d = (r < 2) ? {64{1'b1}} : 64'h0;
            ld_valid = 1'b1;
            ld_data  = d;
            mdl_staging[r] = d;
            check("ld_ready_during_load", {63'd0, ld_ready}, 64'd1);
        end
        @(posedge clk); #1;
        ld_valid    = 1'b0;
        mdl_pending = 1'b1;
        check("ld_ready_after_beat63", {63'd0, ld_ready}, 64'd0);
    endtask

    // Monitor: pops expected beats on every transfer and checks stall stability.
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [5:0]  prev_row;
    logic        prev_last;
    logic [15:0] prev_gen;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {63'd0, dump_valid}, 64'd1);
                check("stall_data",  dump_data, prev_data);
                check("stall_row",   {58'd0, dump_row}, {58'd0, prev_row});
                check("stall_last",  {63'd0, dump_last}, {63'd0, prev_last});
                check("stall_gen",   {48'd0, dump_gen}, {48'd0, prev_gen});
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: row %0d data %h", dump_row, dump_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_row",  {58'd0, dump_row}, {58'd0, e.row});
                    check("beat_data", dump_data, e.data);
                    check("beat_last", {63'd0, dump_last}, {63'd0, e.last});
                    check("beat_gen",  {48'd0, dump_gen}, {48'd0, e.gen});
`ifdef STORE_POPCOUNT_EN
                    check("beat_pop",  {51'd0, dump_pop}, {51'd0, e.pop});
`endif
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
            prev_row   = dump_row;
            prev_last  = dump_last;
            prev_gen   = dump_gen;
        end
    end

    initial begin
        int n;
        int pat[4];
        int diag_rows[4];
        pat       = '{1, 0, 0, 1};
        diag_rows = '{0, 5, 31, 62};
        rst_n = 1'b0;
        row = '0; col = '0; world_we = 1'b0; world_out = 1'b0;
        update_done = 1'b0; ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;
        for (int r = 0; r < 64; r++) begin
            mdl_world[r]   = '0;
            mdl_staging[r] = '0;
        end
        mdl_pending = 1'b0;
        mdl_gen     = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_ready",  {63'd0, ld_ready}, 64'd1);
        check("rst_valid",     {63'd0, dump_valid}, 64'd0);
        check("rst_row",       {58'd0, dump_row}, 64'd0);
        check("rst_last",      {63'd0, dump_last}, 64'd0);
        check("rst_gen",       {48'd0, dump_gen}, 64'd0);
        check("rst_overrun",   {63'd0, dump_overrun}, 64'd0);
        rst_n = 1'b1;

        // Automaton cell port
        row = 6'd5; col = 6'd7; #1;
        check("cell_5_7_init", {63'd0, world_in}, 64'd0);
        write_cell(5, 7, 1'b1);
        check("cell_5_7_wr", {63'd0, world_in}, 64'd1);
        col = 6'd6; #1;
        check("cell_5_6", {63'd0, world_in}, 64'd0);
        write_cell(0, 0, 1'b1);

        // Full-rate dump: exactly 64 consecutive beats
        dump_ready = 1'b1;
        pulse_update(1'b1);
        wait_idle(200, n);
        check("dump_beat_cycles", 64'(n), 64'd64);
        check("dump1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressured dump
        pulse_update(1'b1);
        for (int i = 0; i < 1000 && dump_valid; i++) begin
            dump_ready = pat[i % 4][0];
            @(posedge clk); #1;
        end
        dump_ready = 1'b1;
        check("stall_dump_done", {63'd0, dump_valid}, 64'd0);
        check("dump2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Load a diagonal; refused beats while pending must not land anywhere
        load_world(1'b1);
        ld_valid = 1'b1;
        ld_data  = {64{1'b1}};
        @(posedge clk); #1;
        check("ld_ready_pending", {63'd0, ld_ready}, 64'd0);
        pulse_update(1'b1);
        check("ld_ready_after_commit", {63'd0, ld_ready}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            row = 6'(diag_rows[k]); col = 6'(diag_rows[k]); #1;
            check("diag_cell", {63'd0, world_in}, 64'd1);
            col = 6'(diag_rows[k] + 1); #1;
            check("offdiag_cell", {63'd0, world_in}, 64'd0);
        end
        wait_idle(200, n);
        check("dump3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Overrun: second boundary 10 cycles into a dump (gen restarted at 0)
        pulse_update(1'b1);
        repeat (10) @(posedge clk);
        #1;
        pulse_update(1'b0);
        check("overrun_set", {63'd0, dump_overrun}, 64'd1);
        check("overrun_gen_held", {48'd0, dump_gen}, 64'd1);
        wait_idle(200, n);
        check("overrun_sticky", {63'd0, dump_overrun}, 64'd1);
        check("dump4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Rows 0-1 fully live, committed, then dumped
        load_world(1'b0);
        pulse_update(1'b1);
        wait_idle(200, n);
        pulse_update(1'b1);
        wait_idle(200, n);
        check("dump6_queue_empty", 64'(exp_q.size()), 64'd0);
        row = 6'd1; col = 6'd63; #1;
        check("full_row_cell", {63'd0, world_in}, 64'd1);
        row = 6'd2; col = 6'd0; #1;
        check("empty_row_cell", {63'd0, world_in}, 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/world_store.md
Name: world_store

Overview:
- Owns the 64x64 cell world that the automaton iterates over.
- Serves the automaton's single-cell read/write port.
- Accepts a new initial pattern from a host, row by row, and commits it atomically at a generation boundary.
- On every generation boundary, snapshots the finished world and streams it out one row per beat to a display/host consumer.

Parameters:
- ROWS, 64, number of world rows (row index width fixed at 6).
- COLS, 64, number of world columns; also the load/dump beat width.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  6  automaton cell row index.
- col  in  6  automaton cell column index.
- world_we  in  1  automaton write enable.
- world_out  in  1  cell value written by automaton.
- world_in  out  1  cell value read by automaton.
- update_done  in  1  one-cycle pulse, generation complete.
- ld_valid  in  1  host load beat valid.
- ld_ready  out  1  store can accept a load beat.
- ld_data  in  COLS  one world row; bit c = column c.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts dump beat.
- dump_data  out  COLS  snapshot row; bit c = column c.
- dump_row  out  6  index of the row in dump_data.
- dump_last  out  1  high on row 63 beat.
- dump_gen  out  GEN_W  generation number of the snapshot.
- dump_overrun  out  1  sticky: a snapshot was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - world, staging and shadow arrays cleared to 0.
  - gen_cnt=0, ld_cnt=0, pending=0.
  - ld_ready=1; dump_valid=0, dump_row=0, dump_last=0, dump_gen=0, dump_overrun=0.
  - Reset asserted mid-load or mid-dump aborts that transfer; nothing is resumed.
- Automaton port:
  - world_in = world[row][col], combinational, zero latency.
  - At a posedge with world_we=1: world[row][col] <= world_out.
- Load:
  - ld_ready = !pending.
  - A beat transfers on ld_valid&&ld_ready: staging[ld_cnt] <= ld_data, then ld_cnt increments.
  - Acceptance of the row-63 beat sets pending=1 and wraps ld_cnt to 0.
- Generation boundary, posedge with update_done=1, all in the same edge:
  - a) If the dumper is IDLE: shadow <= world (pre-commit contents); dump_gen <= gen_cnt+1; dumper enters STREAM. Otherwise dump_overrun <= 1 and the snapshot is dropped.
  - b) gen_cnt <= gen_cnt+1, wrapping modulo 2^GEN_W.
  - c) If pending: world <= staging, pending <= 0, gen_cnt <= 0. Commit overrides both (b) and any world_we write on that edge.
- Dumper FSM:
  - IDLE: dump_valid=0.
  - STREAM: dump_valid=1, first beat the cycle after entry, dump_row=0.
  - A beat transfers on dump_valid&&dump_ready, then dump_row increments.
  - dump_data, dump_row, dump_last and dump_gen are held stable while dump_valid&&!dump_ready.
  - After the row-63 beat transfers: return to IDLE, dump_valid=0 on the next cycle.
  - Minimum 64 cycles per dump.
- Simultaneous events:
  - A load beat on the commit edge is refused, because ld_ready=0 whenever pending=1.
  - update_done in the same cycle as the final dump beat: the dumper is still STREAM at that edge, so the overrun rule applies.

Optional Feature:
- Macro: STORE_POPCOUNT_EN.
- Defined:
  - Adds output dump_pop (13 bits): total live cells in the snapshot.
  - Accumulated as rows transfer; valid only on the dump_last beat, 0 on all other beats.
  - Cleared at snapshot entry.
- Undefined:
  - Port and adder are absent.
  - All other behaviour is identical.

Decomposition:
- Package world_pkg:
  - ROWS=64, COLS=64, ROW_W=6, COL_W=6.
  - Typedef row_t = logic[COLS-1:0].
  - Dumper state enum {DUMP_IDLE, DUMP_STREAM}.
- Sub-module world_dumper: shadow array, stream FSM, handshake, overrun flag, optional popcount.
- Top level holds the world array, staging array, load counter and gen_cnt.

Test Plan:
- Reset, then drive row=5, col=7 with no write -> world_in=0. Write world_out=1 at (5,7) -> next cycle world_in=1 at (5,7); (5,6) still 0.
- Load 64 rows, row r = 64'h1<<r -> ld_ready drops after beat 63. Pulse update_done -> (r,r)=1 and (r,r+1)=0; gen_cnt=0; ld_ready=1 again.
- World with (0,0)=1, update_done, dump_ready=1 -> 64 consecutive beats, rows 0..63. Beat 0 data=64'h1, dump_gen=1, dump_last only on row 63.
- dump_ready toggled 1-0-0-1 -> no row skipped or duplicated; dump_data stable during stalls.
- Second update_done 10 cycles into a dump -> dump_overrun=1, stays 1; dump_gen of the active stream unchanged.
- With STORE_POPCOUNT_EN, all cells of rows 0-1 set -> dump_pop=128 on the dump_last beat, 0 on earlier beats.
